// File: rtl/add_serial_pkg.sv
// Shared constants and FSM state encoding for the serial-adder scheduler.
package add_serial_pkg;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } state_e;
endpackage

// File: rtl/add_serial_sched_arb.sv
// Combinational round-robin arbiter: first requester at or after last_grant+1 wins.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);
    logic          w_found;
    logic [IW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(last_grant) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end
endmodule

// File: rtl/add_serial_sched.sv
// Time-shares one fixed-latency adder engine among NREQ requesters,
// one addition in flight, round-robin grant order.
module add_serial_sched
    import add_serial_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ENG_LAT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  busy,
    output logic                  eng_en,
    output logic [WIDTH-1:0]      eng_a,
    output logic [WIDTH-1:0]      eng_b,
    input  logic [WIDTH-1:0]      eng_out,
    output logic [1:0]            o_dbg_state
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(ENG_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(ENG_LAT - 1);

    state_e          r_state, w_next;
    logic [NREQ-1:0] r_grant_oh;
    logic [IW-1:0]   r_grant_idx;
    logic [IW-1:0]   r_last_grant;
    logic [WIDTH-1:0] r_eng_a, r_eng_b, r_rsp_sum;
    logic [CW-1:0]   r_lat_cnt;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_gnt_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .gnt        (w_gnt),
        .gnt_idx    (w_gnt_idx)
    );

    // Handshake: a requester holds req_valid with stable operands until it sees
    // its req_ready pulse; the operands are captured one cycle before that pulse,
    // and the result returns later as a single rsp_valid pulse to the same index.
    always_comb begin
        w_next    = r_state;
        eng_en    = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        case (r_state)
            S_IDLE:  if (|req_valid) w_next = S_ISSUE;
            S_ISSUE: begin
                eng_en    = 1'b1;
                req_ready = r_grant_oh;
                w_next    = S_WAIT;
            end
            S_WAIT:  if (r_lat_cnt == '0) w_next = S_RESP;
            S_RESP: begin
                rsp_valid = r_grant_oh;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_grant_oh   <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= IW'(NREQ - 1);
            r_eng_a      <= '0;
            r_eng_b      <= '0;
            r_rsp_sum    <= '0;
            r_lat_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (|req_valid) begin
                    r_grant_oh  <= w_gnt;
                    r_grant_idx <= w_gnt_idx;
                    r_eng_a     <= req_a[w_gnt_idx*WIDTH +: WIDTH];
                    r_eng_b     <= req_b[w_gnt_idx*WIDTH +: WIDTH];
                end
                S_ISSUE: r_lat_cnt <= LAT_INIT;
                // The engine result is valid exactly on the cycle the count hits zero.
                S_WAIT: begin
                    if (r_lat_cnt == '0) r_rsp_sum <= eng_out;
                    else                 r_lat_cnt <= r_lat_cnt - 1'b1;
                end
                S_RESP: r_last_grant <= r_grant_idx;
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign eng_a       = r_eng_a;
    assign eng_b       = r_eng_b;
    assign rsp_sum     = r_rsp_sum;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_add_serial_sched.sv
// Randomised scoreboard bench for add_serial_sched (ENG_LAT=10 and ENG_LAT=1 builds).
module tb_add_serial_sched;
    import add_serial_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int LAT  = 10;
    localparam int LAT1 = 1;

    typedef struct {
        int          idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        int          rdy_cyc;
        int          rsp_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic [W-1:0]        rsp_sum, eng_a, eng_b, eng_out;
    logic                busy, eng_en;
    logic [1:0]          dbg;
    logic [NREQ-1:0]     req_valid1, req_ready1, rsp_valid1;
    logic [NREQ*W-1:0]   req_a1, req_b1;
    logic [W-1:0]        rsp_sum1, eng_a1, eng_b1, eng_out1;
    logic                busy1, eng_en1;
    logic [1:0]          dbg1;

    add_serial_sched #(.NREQ(NREQ), .WIDTH(W), .ENG_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
        .busy(busy), .eng_en(eng_en), .eng_a(eng_a), .eng_b(eng_b),
        .eng_out(eng_out), .o_dbg_state(dbg)
    );

    add_serial_sched #(.NREQ(NREQ), .WIDTH(W), .ENG_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .rsp_valid(rsp_valid1), .rsp_sum(rsp_sum1),
        .busy(busy1), .eng_en(eng_en1), .eng_a(eng_a1), .eng_b(eng_b1),
        .eng_out(eng_out1), .o_dbg_state(dbg1)
    );

    // Engine models: the sum appears LAT cycles after eng_en, junk otherwise.
    logic [W-1:0] pipe [LAT];
    logic [W-1:0] pipe1;
    always @(posedge clk) begin
        pipe[0] <= eng_en ? W'(eng_a + eng_b) : W'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        pipe1 <= eng_en1 ? W'(eng_a1 + eng_b1) : W'($urandom);
    end
    assign eng_out  = pipe[LAT-1];
    assign eng_out1 = pipe1;

    int cyc = 0;
    bit started = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
    end

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t exp1_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pending set, rotating priority, fixed ENG_LAT+3 turnaround.
    bit           model_pend [NREQ];
    logic [W-1:0] model_a [NREQ];
    logic [W-1:0] model_b [NREQ];
    int           model_last;
    int           model_free;
    int           refill [NREQ];

    task automatic model_reset();
        model_last = NREQ - 1;
        model_free = 0;
    endtask

    task automatic model_step();
        int g;
        exp_t e;
        if (rst && cyc >= model_free) begin
            for (int s = 1; s <= NREQ; s++) begin
                g = (model_last + s) % NREQ;
                if (model_pend[g]) begin
                    e.idx = g; e.a = model_a[g]; e.b = model_b[g];
                    e.sum = model_a[g] + model_b[g];
                    e.rdy_cyc = cyc + 1;
                    e.rsp_cyc = cyc + 2 + LAT;
                    exp_q.push_back(e);
                    model_pend[g] = 1'b0;
                    model_last = g;
                    model_free = cyc + LAT + 3;
                    break;
                end
            end
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
        model_pend[i]   = 1'b1;
        model_a[i]      = a;
        model_b[i]      = b;
    endtask

    task automatic set_req1(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        req_a1[i*W +: W] = a;
        req_b1[i*W +: W] = b;
        req_valid1[i]    = 1'b1;
        e.idx = i; e.a = a; e.b = b; e.sum = a + b;
        e.rdy_cyc = cyc + 1;
        e.rsp_cyc = cyc + 2 + LAT1;
        exp1_q.push_back(e);
    endtask

    task automatic handle_ready();
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] === 1'b1) begin
                if (refill[i] > 0) begin
                    refill[i]--;
                    set_req(i, W'($urandom), W'($urandom));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            if (req_ready1[i] === 1'b1) req_valid1[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        handle_ready();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_pend();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++) p |= model_pend[i];
        return p;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0 || any_pend()) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    // Monitor: compares DUT outputs each cycle against the queue heads.
    exp_t h, h1;
    bit have, have1;
    logic [NREQ-1:0] e_rdy, e_rsp, e_rdy1, e_rsp1;
    logic e_busy, e_busy1;
    always @(negedge clk) begin
        if (started) begin
            e_rdy = '0; e_rsp = '0; e_busy = 1'b0;
            have = (exp_q.size() > 0);
            if (have) begin
                h = exp_q[0];
                if (h.rdy_cyc == cyc) e_rdy[h.idx] = 1'b1;
                if (h.rsp_cyc == cyc) e_rsp[h.idx] = 1'b1;
                e_busy = (cyc >= h.rdy_cyc) && (cyc <= h.rsp_cyc);
            end
            chk("busy", 32'(busy), 32'(e_busy));
            if (e_rdy != '0 || req_ready != '0) chk("req_ready", 32'(req_ready), 32'(e_rdy));
            if (e_rdy != '0 || eng_en != 1'b0)  chk("eng_en", 32'(eng_en), 32'(e_rdy != '0));
            if (e_busy) begin
                chk("eng_a_hold", 32'(eng_a), 32'(h.a));
                chk("eng_b_hold", 32'(eng_b), 32'(h.b));
            end
            if (e_rsp != '0 || rsp_valid != '0) chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            if (e_rsp != '0) begin
                chk("rsp_sum", 32'(rsp_sum), 32'(h.sum));
                void'(exp_q.pop_front());
            end

            e_rdy1 = '0; e_rsp1 = '0; e_busy1 = 1'b0;
            have1 = (exp1_q.size() > 0);
            if (have1) begin
                h1 = exp1_q[0];
                if (h1.rdy_cyc == cyc) e_rdy1[h1.idx] = 1'b1;
                if (h1.rsp_cyc == cyc) e_rsp1[h1.idx] = 1'b1;
                e_busy1 = (cyc >= h1.rdy_cyc) && (cyc <= h1.rsp_cyc);
            end
            chk("busy_lat1", 32'(busy1), 32'(e_busy1));
            if (e_rdy1 != '0 || req_ready1 != '0) chk("req_ready_lat1", 32'(req_ready1), 32'(e_rdy1));
            if (e_rdy1 != '0 || eng_en1 != 1'b0) chk("eng_en_lat1", 32'(eng_en1), 32'(e_rdy1 != '0));
            if (e_rdy1 != '0) chk("eng_a_lat1", 32'(eng_a1), 32'(h1.a));
            if (e_rsp1 != '0 || rsp_valid1 != '0) chk("rsp_valid_lat1", 32'(rsp_valid1), 32'(e_rsp1));
            if (e_rsp1 != '0) begin
                chk("rsp_sum_lat1", 32'(rsp_sum1), 32'(h1.sum));
                void'(exp1_q.pop_front());
            end

            // A reset sampled at the coming edge drops whatever was in flight.
            if (!rst) begin
                exp_q.delete();
                exp1_q.delete();
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int ri;
        rst = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        req_valid1 = '0; req_a1 = '0; req_b1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            model_pend[i] = 1'b0; model_a[i] = '0; model_b[i] = '0; refill[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(dbg), 32'(ST_IDLE));
        chk("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("reset_eng_a", 32'(eng_a), 32'd0);
        rst = 1'b1;

        // All four held valid: expect 0,1,2,3,0,1,2,3 back to back.
        for (int i = 0; i < NREQ; i++) begin
            refill[i] = 1;
            set_req(i, W'($urandom), W'($urandom));
        end
        drain(400);

        set_req(0, 8'h12, 8'h34);
        drain(60);
        set_req(2, 8'hF0, 8'h25);
        drain(60);

        // Late arrival while requester 0 waits on the engine.
        set_req(0, 8'h3C, 8'h41);
        repeat (4) tick();
        set_req(1, 8'h99, 8'h88);
        drain(100);

        // Reset in the middle of WAIT.
        set_req(1, 8'h77, 8'h11);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        model_reset();
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_eng_a", 32'(eng_a), 32'd0);
        chk("rst_mid_eng_b", 32'(eng_b), 32'd0);
        chk("rst_mid_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_mid_state", 32'(dbg), 32'(ST_IDLE));
        rst = 1'b1;
        set_req(3, 8'hA5, 8'h5A);
        set_req(0, 8'h0F, 8'h01);
        drain(100);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                ri = int'($urandom_range(0, NREQ - 1));
                if (!req_valid[ri] && !model_pend[ri]) set_req(ri, W'($urandom), W'($urandom));
            end
            tick();
        end
        drain(300);

        // ENG_LAT=1 build.
        set_req1(0, 8'h01, 8'hFF);
        drain(20);
        for (int n = 0; n < 4; n++) begin
            set_req1(int'($urandom_range(0, NREQ - 1)), W'($urandom), W'($urandom));
            drain(20);
        end
        repeat (3) tick();
        chk("lat1_idle_state", 32'(dbg1), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
